id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register and operand-forwarding stage directly upstream of the EX-stage ALU. Captures decoded fields each cycle, inserts bubbles on flush or load-use hazard, and holds on stall. Combinationally selects forwarded operands from EX/MEM or MEM/WB to drive the ALU's `x`, `y`, `shamt` and `ALUout` inputs. Also passes destination register, store data and memory/write-back control to the EX/MEM register.

## Interface
- `DW`, default 32: datapath width.
- `RW`, default 5: register-address width.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall_i` in 1: hold all ID/EX state.
- `flush_i` in 1: replace the next captured entry with a bubble.
- `id_valid_i` in 1: decode slot holds a real instruction.
- `id_rs_data_i`, `id_rt_data_i`, `id_imm_i` in DW each: register-file reads and the sign-extended immediate.
- `id_rs_i`, `id_rt_i`, `id_rd_i` in RW each: register addresses.
- `id_shamt_i` in 5: shift amount.
- `id_alu_ctrl_i` in 4: ALU control code.
- `id_alu_src_i`, `id_reg_dst_i` in 1 each: operand-B select and destination select.
- `id_uses_rs_i`, `id_uses_rt_i` in 1 each: decode reads rs / rt.
- `id_reg_write_i`, `id_mem_read_i`, `id_mem_write_i`, `id_mem_to_reg_i` in 1 each: control for later stages.
- `exm_reg_write_i` in 1, `exm_rd_i` in RW, `exm_result_i` in DW: EX/MEM forwarding source.
- `wb_reg_write_i` in 1, `wb_rd_i` in RW, `wb_result_i` in DW: MEM/WB forwarding source.
- `alu_x_o`, `alu_y_o` out DW each: ALU operands.
- `alu_shamt_o` out 5: ALU shift amount.
- `alu_ctrl_o` out 4: ALU control code.
- `store_data_o` out DW: forwarded rt value.
- `dest_o` out RW: destination register.
- `ex_valid_o`, `ex_reg_write_o`, `ex_mem_read_o`, `ex_mem_write_o`, `ex_mem_to_reg_o` out 1 each: registered control.
- `load_use_o` out 1: load-use hazard; upstream freezes PC and IF/ID while it is high.
- `fwd_a_o`, `fwd_b_o` out 2 each: forwarding select for rs / rt (debug/verification).

## Operation
- Register update priority, highest first:
  - `flush_i`: bubble.
  - `stall_i`: hold.
  - `load_use_o`: bubble.
  - otherwise: capture all `id_*` inputs.
- Bubble: `ex_valid`, `reg_write`, `mem_read`, `mem_write` and `mem_to_reg` cleared. Data fields are don't-care, but the implementation clears them to 0.
- `load_use_o` = registered `mem_read` & `valid` & (`dest` != 0) & ((`dest` == `id_rs_i` & `id_uses_rs_i`) | (`dest` == `id_rt_i` & `id_uses_rt_i`)).
- `dest` = `reg_dst_q` ? `rd_q` : `rt_q`; `dest_o` is this value.
- Forward select, applied to rs and rt independently (shown for rs):
  - FWD_EXM (2'b01) if `exm_reg_write_i` & `exm_rd_i` != 0 & `exm_rd_i` == `rs_q`.
  - else FWD_WB (2'b10) if `wb_reg_write_i` & `wb_rd_i` != 0 & `wb_rd_i` == `rs_q`.
  - else FWD_NONE (2'b00).
  - EX/MEM beats MEM/WB when both match.
- `alu_x_o` = forwarded rs. `store_data_o` = forwarded rt. `alu_y_o` = `alu_src_q` ? `imm_q` : forwarded rt.
- `alu_shamt_o` and `alu_ctrl_o` are the registered fields, passed through unmodified.
- Register 0 is never forwarded; its read value comes from the register file.
- No arithmetic is performed here; all paths are full DW width with no truncation.

## Timing
- Capture latency: 1 cycle from `id_*` to registered fields.
- Forwarding muxes and `load_use_o` are combinational from registered state plus current inputs. No added latency.
- Reset (asynchronous, `rst_n` low): every registered field is 0, so `alu_ctrl_o` = 4'b0000, all control outputs are 0, `dest_o` = 0 and `load_use_o` = 0.
  - With forwarding inputs idle, `alu_x_o`, `alu_y_o`, `store_data_o`, `fwd_a_o` and `fwd_b_o` are also 0.
  - Deasserting reset mid-program resumes by capturing on the first rising edge after release.
- `flush_i` together with `stall_i`: bubble. A flush is never lost.
- `stall_i` together with `load_use_o`: hold. The load stays in EX and `load_use_o` stays high.
- Load-use resolves after exactly one bubble: the load advances, and the dependent instruction is captured on the next edge and takes its operand via FWD_WB.

## Structure
- Shared package `pipe_pkg`:
  - ALU control constants ALU_AND 0000, ALU_OR 0001, ALU_ADD 0010, ALU_XOR 0101, ALU_SUB 0110, ALU_SLT 0111, ALU_SRL 1000, ALU_ADDU 1010, ALU_NOR 1100, ALU_SUBU 1110, ALU_SLL 1111.
  - Forward-select constants FWD_NONE, FWD_EXM, FWD_WB.
  - The RW constant.
- One sub-module `fwd_mux`, instantiated twice (rs, rt). It takes the source address, registered data and both forwarding sources, and returns the 2-bit select and the DW-wide data.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream → all outputs 0 immediately; release → next captured add (rs=1, rt=2, data 5/7) gives `alu_x_o`=5, `alu_y_o`=7, `alu_ctrl_o`=0010.
- **EX/MEM forwarding:** `exm_rd_i`=3, `exm_result_i`=0xAAAA0000, registered rs=3 → `alu_x_o`=0xAAAA0000, `fwd_a_o`=01. Adding the same match on MEM/WB (0x1234) still selects 0xAAAA0000.
- **Register 0:** `exm_rd_i`=0, `exm_reg_write_i`=1, rs=0 → `fwd_a_o`=00 and the register-file value is used.
- **Immediate path:** `alu_src`=1, imm=0xFFFFFFFC, rt forwarded 0x55 → `alu_y_o`=0xFFFFFFFC, `store_data_o`=0x55.
- **Load-use:** lw to $4 in EX, decode add with rs=4 → `load_use_o`=1, next cycle `ex_valid_o`=0. The cycle after, the add is captured with `fwd_a_o`=10.
- **Stall/flush priority:**
  - `stall_i`=1 for 3 cycles → outputs unchanged.
  - `stall_i`=`flush_i`=1 → bubble next edge, `ex_reg_write_o`=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the ID/EX stage and its forwarding muxes:
//   - RW            : register-address width
//   - ALU_*         : 4-bit ALU control codes understood by the EX-stage ALU
//   - fwd_sel_e     : operand forwarding select (none / EX-MEM / MEM-WB)
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int RW = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_ADDU = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_SUBU = 4'b1110;
    localparam logic [3:0] ALU_SLL  = 4'b1111;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_EXM  = 2'b01,
        FWD_WB   = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundles every non-clock/reset signal of the ID/EX stage.
//   master : the surrounding pipeline (decode, hazard control, EX/MEM, MEM/WB)
//            drives the *_i signals and observes the *_o signals.
//   slave  : the id_ex_stage itself.
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
    parameter int DW = 32,
    parameter int RW = pipe_pkg::RW
);
    // Pipeline control
    logic          stall_i;
    logic          flush_i;

    // Decode slot
    logic          id_valid_i;
    logic [DW-1:0] id_rs_data_i;
    logic [DW-1:0] id_rt_data_i;
    logic [DW-1:0] id_imm_i;
    logic [RW-1:0] id_rs_i;
    logic [RW-1:0] id_rt_i;
    logic [RW-1:0] id_rd_i;
    logic [4:0]    id_shamt_i;
    logic [3:0]    id_alu_ctrl_i;
    logic          id_alu_src_i;
    logic          id_reg_dst_i;
    logic          id_uses_rs_i;
    logic          id_uses_rt_i;
    logic          id_reg_write_i;
    logic          id_mem_read_i;
    logic          id_mem_write_i;
    logic          id_mem_to_reg_i;

    // Forwarding sources
    logic          exm_reg_write_i;
    logic [RW-1:0] exm_rd_i;
    logic [DW-1:0] exm_result_i;
    logic          wb_reg_write_i;
    logic [RW-1:0] wb_rd_i;
    logic [DW-1:0] wb_result_i;

    // ALU / EX-MEM side
    logic [DW-1:0] alu_x_o;
    logic [DW-1:0] alu_y_o;
    logic [4:0]    alu_shamt_o;
    logic [3:0]    alu_ctrl_o;
    logic [DW-1:0] store_data_o;
    logic [RW-1:0] dest_o;
    logic          ex_valid_o;
    logic          ex_reg_write_o;
    logic          ex_mem_read_o;
    logic          ex_mem_write_o;
    logic          ex_mem_to_reg_o;
    logic          load_use_o;
    logic [1:0]    fwd_a_o;
    logic [1:0]    fwd_b_o;

    modport master (
        output stall_i, flush_i,
        output id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
        output id_rs_i, id_rt_i, id_rd_i, id_shamt_i, id_alu_ctrl_i,
        output id_alu_src_i, id_reg_dst_i, id_uses_rs_i, id_uses_rt_i,
        output id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i,
        output exm_reg_write_i, exm_rd_i, exm_result_i,
        output wb_reg_write_i, wb_rd_i, wb_result_i,
        input  alu_x_o, alu_y_o, alu_shamt_o, alu_ctrl_o, store_data_o, dest_o,
        input  ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
        input  ex_mem_to_reg_o, load_use_o, fwd_a_o, fwd_b_o
    );

    modport slave (
        input  stall_i, flush_i,
        input  id_valid_i, id_rs_data_i, id_rt_data_i, id_imm_i,
        input  id_rs_i, id_rt_i, id_rd_i, id_shamt_i, id_alu_ctrl_i,
        input  id_alu_src_i, id_reg_dst_i, id_uses_rs_i, id_uses_rt_i,
        input  id_reg_write_i, id_mem_read_i, id_mem_write_i, id_mem_to_reg_i,
        input  exm_reg_write_i, exm_rd_i, exm_result_i,
        input  wb_reg_write_i, wb_rd_i, wb_result_i,
        output alu_x_o, alu_y_o, alu_shamt_o, alu_ctrl_o, store_data_o, dest_o,
        output ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
        output ex_mem_to_reg_o, load_use_o, fwd_a_o, fwd_b_o
    );

endinterface

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Operand forwarding selector for one source register.
//   src_addr_i                 : register address read by the instruction in EX
//   reg_data_i                 : value read from the register file at decode
//   exm_reg_write_i/rd_i/result_i : EX/MEM write-back candidate
//   wb_reg_write_i/rd_i/result_i  : MEM/WB write-back candidate
//   sel_o                      : which source was chosen
//   data_o                     : forwarded operand, full DW width
// ---------------------------------------------------------------------------
module fwd_mux #(
    parameter int DW = 32,
    parameter int RW = pipe_pkg::RW
) (
    input  logic               [RW-1:0] src_addr_i,
    input  logic               [DW-1:0] reg_data_i,
    input  logic                        exm_reg_write_i,
    input  logic               [RW-1:0] exm_rd_i,
    input  logic               [DW-1:0] exm_result_i,
    input  logic                        wb_reg_write_i,
    input  logic               [RW-1:0] wb_rd_i,
    input  logic               [DW-1:0] wb_result_i,
    output pipe_pkg::fwd_sel_e          sel_o,
    output logic               [DW-1:0] data_o
);
    import pipe_pkg::*;

    // The younger producer (EX/MEM) wins over MEM/WB. Register 0 is hardwired,
    // so a write to it is never treated as a forwarding source.
    always_comb begin
        sel_o  = FWD_NONE;
        data_o = reg_data_i;
        if (exm_reg_write_i && (exm_rd_i != '0) && (exm_rd_i == src_addr_i)) begin
            sel_o  = FWD_EXM;
            data_o = exm_result_i;
        end else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == src_addr_i)) begin
            sel_o  = FWD_WB;
            data_o = wb_result_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus operand forwarding in front of the EX ALU.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : id_ex_stage_if.slave carrying
//       stall_i / flush_i           pipeline control
//       id_*                        decoded fields captured each cycle
//       exm_* / wb_*                forwarding sources
//       alu_* / store_data_o        forwarded ALU operands and store data
//       dest_o / ex_*               destination and control for EX/MEM
//       load_use_o                  load-use hazard to freeze PC and IF/ID
//       fwd_a_o / fwd_b_o           forwarding selects for rs / rt
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = pipe_pkg::RW
) (
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);
    import pipe_pkg::*;

    logic          valid_q,      valid_d;
    logic [DW-1:0] rs_data_q,    rs_data_d;
    logic [DW-1:0] rt_data_q,    rt_data_d;
    logic [DW-1:0] imm_q,        imm_d;
    logic [RW-1:0] rs_q,         rs_d;
    logic [RW-1:0] rt_q,         rt_d;
    logic [RW-1:0] rd_q,         rd_d;
    logic [4:0]    shamt_q,      shamt_d;
    logic [3:0]    alu_ctrl_q,   alu_ctrl_d;
    logic          alu_src_q,    alu_src_d;
    logic          reg_dst_q,    reg_dst_d;
    logic          reg_write_q,  reg_write_d;
    logic          mem_read_q,   mem_read_d;
    logic          mem_write_q,  mem_write_d;
    logic          mem_to_reg_q, mem_to_reg_d;

    logic [RW-1:0] dest;
    logic          load_use;
    fwd_sel_e      fwd_a;
    fwd_sel_e      fwd_b;
    logic [DW-1:0] rs_fwd;
    logic [DW-1:0] rt_fwd;

    assign dest = reg_dst_q ? rd_q : rt_q;

    // A load in EX whose destination is read by the instruction in decode
    // cannot be forwarded in time; one bubble lets the load reach WB first.
    assign load_use = mem_read_q && valid_q && (dest != '0) &&
                      (((dest == bus.id_rs_i) && bus.id_uses_rs_i) ||
                       ((dest == bus.id_rt_i) && bus.id_uses_rt_i));

    // Flush beats stall so a flush is never lost; stall beats the load-use
    // bubble so a stalled load stays in EX with load_use still raised.
    // Bubbles clear every field, not just the control bits.
    always_comb begin
        valid_d      = valid_q;
        rs_data_d    = rs_data_q;
        rt_data_d    = rt_data_q;
        imm_d        = imm_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        rd_d         = rd_q;
        shamt_d      = shamt_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_src_d    = alu_src_q;
        reg_dst_d    = reg_dst_q;
        reg_write_d  = reg_write_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_to_reg_d = mem_to_reg_q;
        if (bus.flush_i || (!bus.stall_i && load_use)) begin
            valid_d      = 1'b0;
            rs_data_d    = '0;
            rt_data_d    = '0;
            imm_d        = '0;
            rs_d         = '0;
            rt_d         = '0;
            rd_d         = '0;
            shamt_d      = '0;
            alu_ctrl_d   = '0;
            alu_src_d    = 1'b0;
            reg_dst_d    = 1'b0;
            reg_write_d  = 1'b0;
            mem_read_d   = 1'b0;
            mem_write_d  = 1'b0;
            mem_to_reg_d = 1'b0;
        end else if (!bus.stall_i) begin
            valid_d      = bus.id_valid_i;
            rs_data_d    = bus.id_rs_data_i;
            rt_data_d    = bus.id_rt_data_i;
            imm_d        = bus.id_imm_i;
            rs_d         = bus.id_rs_i;
            rt_d         = bus.id_rt_i;
            rd_d         = bus.id_rd_i;
            shamt_d      = bus.id_shamt_i;
            alu_ctrl_d   = bus.id_alu_ctrl_i;
            alu_src_d    = bus.id_alu_src_i;
            reg_dst_d    = bus.id_reg_dst_i;
            reg_write_d  = bus.id_reg_write_i;
            mem_read_d   = bus.id_mem_read_i;
            mem_write_d  = bus.id_mem_write_i;
            mem_to_reg_d = bus.id_mem_to_reg_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            rs_data_q    <= '0;
            rt_data_q    <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            shamt_q      <= '0;
            alu_ctrl_q   <= '0;
            alu_src_q    <= 1'b0;
            reg_dst_q    <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rs_data_q    <= rs_data_d;
            rt_data_q    <= rt_data_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            shamt_q      <= shamt_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src_q    <= alu_src_d;
            reg_dst_q    <= reg_dst_d;
            reg_write_q  <= reg_write_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_to_reg_q <= mem_to_reg_d;
        end
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .src_addr_i      (rs_q),
        .reg_data_i      (rs_data_q),
        .exm_reg_write_i (bus.exm_reg_write_i),
        .exm_rd_i        (bus.exm_rd_i),
        .exm_result_i    (bus.exm_result_i),
        .wb_reg_write_i  (bus.wb_reg_write_i),
        .wb_rd_i         (bus.wb_rd_i),
        .wb_result_i     (bus.wb_result_i),
        .sel_o           (fwd_a),
        .data_o          (rs_fwd)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .src_addr_i      (rt_q),
        .reg_data_i      (rt_data_q),
        .exm_reg_write_i (bus.exm_reg_write_i),
        .exm_rd_i        (bus.exm_rd_i),
        .exm_result_i    (bus.exm_result_i),
        .wb_reg_write_i  (bus.wb_reg_write_i),
        .wb_rd_i         (bus.wb_rd_i),
        .wb_result_i     (bus.wb_result_i),
        .sel_o           (fwd_b),
        .data_o          (rt_fwd)
    );

    assign bus.alu_x_o         = rs_fwd;
    assign bus.alu_y_o         = alu_src_q ? imm_q : rt_fwd;
    assign bus.store_data_o    = rt_fwd;
    assign bus.alu_shamt_o     = shamt_q;
    assign bus.alu_ctrl_o      = alu_ctrl_q;
    assign bus.dest_o          = dest;
    assign bus.ex_valid_o      = valid_q;
    assign bus.ex_reg_write_o  = reg_write_q;
    assign bus.ex_mem_read_o   = mem_read_q;
    assign bus.ex_mem_write_o  = mem_write_q;
    assign bus.ex_mem_to_reg_o = mem_to_reg_q;
    assign bus.load_use_o      = load_use;
    assign bus.fwd_a_o         = fwd_a;
    assign bus.fwd_b_o         = fwd_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Directed scenarios followed by random traffic, all checked against a
// behavioural model of the instruction sitting in the EX slot.
// ---------------------------------------------------------------------------
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(DW), .RW(RW)) bus ();

    id_ex_stage #(.DW(DW), .RW(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // The instruction the model believes is currently in EX
    typedef struct {
        bit          valid;
        logic [31:0] rsData;
        logic [31:0] rtData;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [3:0]  ctrl;
        bit          aluSrc;
        bit          regDst;
        bit          regWrite;
        bit          memRead;
        bit          memWrite;
        bit          memToReg;
    } slotT;

    slotT modelSlot;

    // Single point of comparison: counts and reports
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [4:0] modelDest();
        return modelSlot.regDst ? modelSlot.rd : modelSlot.rt;
    endfunction

    // Youngest writer of a nonzero register supplies the value
    function automatic logic [31:0] modelForward(input logic [4:0] addr, input logic [31:0] rfVal,
                                                 output logic [1:0] sel);
        sel = 2'b00;
        if (addr == 5'd0) return rfVal;
        if (bus.exm_reg_write_i && bus.exm_rd_i == addr) begin
            sel = 2'b01;
            return bus.exm_result_i;
        end
        if (bus.wb_reg_write_i && bus.wb_rd_i == addr) begin
            sel = 2'b10;
            return bus.wb_result_i;
        end
        return rfVal;
    endfunction

    function automatic bit modelLoadUse();
        logic [4:0] d;
        d = modelDest();
        if (!(modelSlot.valid && modelSlot.memRead) || d == 5'd0) return 1'b0;
        return (bus.id_uses_rs_i && bus.id_rs_i == d) || (bus.id_uses_rt_i && bus.id_rt_i == d);
    endfunction

    function automatic slotT modelNext();
        slotT s;
        s = '{default: 0};
        if (bus.flush_i) return s;
        if (bus.stall_i) return modelSlot;
        if (modelLoadUse()) return s;
        s.valid    = bus.id_valid_i;
        s.rsData   = bus.id_rs_data_i;
        s.rtData   = bus.id_rt_data_i;
        s.imm      = bus.id_imm_i;
        s.rs       = bus.id_rs_i;
        s.rt       = bus.id_rt_i;
        s.rd       = bus.id_rd_i;
        s.shamt    = bus.id_shamt_i;
        s.ctrl     = bus.id_alu_ctrl_i;
        s.aluSrc   = bus.id_alu_src_i;
        s.regDst   = bus.id_reg_dst_i;
        s.regWrite = bus.id_reg_write_i;
        s.memRead  = bus.id_mem_read_i;
        s.memWrite = bus.id_mem_write_i;
        s.memToReg = bus.id_mem_to_reg_i;
        return s;
    endfunction

    // Compare every output against the model
    task automatic checkAll();
        logic [1:0]  selA, selB;
        logic [31:0] a, b;
        a = modelForward(modelSlot.rs, modelSlot.rsData, selA);
        b = modelForward(modelSlot.rt, modelSlot.rtData, selB);
        checkOutput("alu_x",      bus.alu_x_o, a);
        checkOutput("alu_y",      bus.alu_y_o, modelSlot.aluSrc ? modelSlot.imm : b);
        checkOutput("store_data", bus.store_data_o, b);
        checkOutput("shamt",      32'(bus.alu_shamt_o), 32'(modelSlot.shamt));
        checkOutput("alu_ctrl",   32'(bus.alu_ctrl_o), 32'(modelSlot.ctrl));
        checkOutput("dest",       32'(bus.dest_o), 32'(modelDest()));
        checkOutput("ex_valid",   32'(bus.ex_valid_o), 32'(modelSlot.valid));
        checkOutput("reg_write",  32'(bus.ex_reg_write_o), 32'(modelSlot.regWrite));
        checkOutput("mem_read",   32'(bus.ex_mem_read_o), 32'(modelSlot.memRead));
        checkOutput("mem_write",  32'(bus.ex_mem_write_o), 32'(modelSlot.memWrite));
        checkOutput("mem_to_reg", 32'(bus.ex_mem_to_reg_o), 32'(modelSlot.memToReg));
        checkOutput("load_use",   32'(bus.load_use_o), 32'(modelLoadUse()));
        checkOutput("fwd_a",      32'(bus.fwd_a_o), 32'(selA));
        checkOutput("fwd_b",      32'(bus.fwd_b_o), 32'(selB));
    endtask

    task automatic setIdle();
        bus.stall_i = 0;          bus.flush_i = 0;
        bus.id_valid_i = 0;       bus.id_rs_data_i = '0;   bus.id_rt_data_i = '0;
        bus.id_imm_i = '0;        bus.id_rs_i = '0;        bus.id_rt_i = '0;
        bus.id_rd_i = '0;         bus.id_shamt_i = '0;     bus.id_alu_ctrl_i = '0;
        bus.id_alu_src_i = 0;     bus.id_reg_dst_i = 0;    bus.id_uses_rs_i = 0;
        bus.id_uses_rt_i = 0;     bus.id_reg_write_i = 0;  bus.id_mem_read_i = 0;
        bus.id_mem_write_i = 0;   bus.id_mem_to_reg_i = 0;
        bus.exm_reg_write_i = 0;  bus.exm_rd_i = '0;       bus.exm_result_i = '0;
        bus.wb_reg_write_i = 0;   bus.wb_rd_i = '0;        bus.wb_result_i = '0;
    endtask

    task automatic loadInstr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                             input logic [31:0] rsData, input logic [31:0] rtData,
                             input logic [31:0] imm, input logic [3:0] ctrl,
                             input bit aluSrc, input bit regDst, input bit memRead);
        bus.id_valid_i = 1;       bus.id_rs_i = rs;        bus.id_rt_i = rt;
        bus.id_rd_i = rd;         bus.id_rs_data_i = rsData; bus.id_rt_data_i = rtData;
        bus.id_imm_i = imm;       bus.id_alu_ctrl_i = ctrl; bus.id_shamt_i = 5'd0;
        bus.id_alu_src_i = aluSrc; bus.id_reg_dst_i = regDst;
        bus.id_uses_rs_i = 1;     bus.id_uses_rt_i = !aluSrc;
        bus.id_reg_write_i = 1;   bus.id_mem_read_i = memRead;
        bus.id_mem_write_i = 0;   bus.id_mem_to_reg_i = memRead;
    endtask

    task automatic applyStimulus();
        bus.stall_i          = ($urandom_range(0, 4) == 0);
        bus.flush_i          = ($urandom_range(0, 7) == 0);
        bus.id_valid_i       = ($urandom_range(0, 5) != 0);
        bus.id_rs_data_i     = $urandom;
        bus.id_rt_data_i     = $urandom;
        bus.id_imm_i         = $urandom;
        bus.id_rs_i          = 5'($urandom_range(0, 7));
        bus.id_rt_i          = 5'($urandom_range(0, 7));
        bus.id_rd_i          = 5'($urandom_range(0, 7));
        bus.id_shamt_i       = 5'($urandom);
        bus.id_alu_ctrl_i    = 4'($urandom);
        bus.id_alu_src_i     = 1'($urandom);
        bus.id_reg_dst_i     = 1'($urandom);
        bus.id_uses_rs_i     = 1'($urandom);
        bus.id_uses_rt_i     = 1'($urandom);
        bus.id_reg_write_i   = 1'($urandom);
        bus.id_mem_read_i    = 1'($urandom);
        bus.id_mem_write_i   = 1'($urandom);
        bus.id_mem_to_reg_i  = 1'($urandom);
        bus.exm_reg_write_i  = 1'($urandom);
        bus.exm_rd_i         = 5'($urandom_range(0, 7));
        bus.exm_result_i     = $urandom;
        bus.wb_reg_write_i   = 1'($urandom);
        bus.wb_rd_i          = 5'($urandom_range(0, 7));
        bus.wb_result_i      = $urandom;
    endtask

    // Called just after a falling edge with inputs set: check, then advance
    task automatic stepCycle();
        slotT nxt;
        #1;
        checkAll();
        nxt = modelNext();
        @(posedge clk);
        modelSlot = nxt;
        @(negedge clk);
    endtask

    initial begin
        modelSlot = '{default: 0};
        setIdle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        #1;
        checkAll();
        checkOutput("reset_ctrl", 32'(bus.alu_ctrl_o), 32'(4'b0000));

        // Release reset and capture add rs=1, rt=2
        @(negedge clk);
        rst_n = 1;
        loadInstr(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, ALU_ADD, 0, 1, 0);
        stepCycle();
        setIdle();
        #1;
        checkOutput("add_x", bus.alu_x_o, 32'd5);
        checkOutput("add_y", bus.alu_y_o, 32'd7);
        checkOutput("add_ctrl", 32'(bus.alu_ctrl_o), 32'(4'b0010));

        // EX/MEM forwarding, then EX/MEM beating MEM/WB
        loadInstr(5'd3, 5'd0, 5'd8, 32'h11, 32'h0, 32'h0, ALU_OR, 0, 1, 0);
        stepCycle();
        setIdle();
        bus.exm_reg_write_i = 1; bus.exm_rd_i = 5'd3; bus.exm_result_i = 32'hAAAA0000;
        #1;
        checkOutput("exm_x", bus.alu_x_o, 32'hAAAA0000);
        checkOutput("exm_fwd_a", 32'(bus.fwd_a_o), 32'(2'b01));
        bus.wb_reg_write_i = 1; bus.wb_rd_i = 5'd3; bus.wb_result_i = 32'h1234;
        #1;
        checkOutput("exm_wins_x", bus.alu_x_o, 32'hAAAA0000);
        checkAll();

        // Register 0 never forwarded
        setIdle();
        loadInstr(5'd0, 5'd1, 5'd2, 32'h77, 32'h1, 32'h0, ALU_AND, 0, 1, 0);
        stepCycle();
        setIdle();
        bus.exm_reg_write_i = 1; bus.exm_rd_i = 5'd0; bus.exm_result_i = 32'hDEAD;
        #1;
        checkOutput("r0_fwd_a", 32'(bus.fwd_a_o), 32'(2'b00));
        checkOutput("r0_x", bus.alu_x_o, 32'h77);

        // Immediate operand while store data still forwards
        setIdle();
        loadInstr(5'd1, 5'd6, 5'd7, 32'h1, 32'h99, 32'hFFFFFFFC, ALU_ADD, 1, 0, 0);
        stepCycle();
        setIdle();
        bus.exm_reg_write_i = 1; bus.exm_rd_i = 5'd6; bus.exm_result_i = 32'h55;
        #1;
        checkOutput("imm_y", bus.alu_y_o, 32'hFFFFFFFC);
        checkOutput("imm_store", bus.store_data_o, 32'h55);

        // Load-use: lw $4, stall once with hazard, then one bubble, then WB forward
        setIdle();
        loadInstr(5'd2, 5'd4, 5'd0, 32'h0, 32'h0, 32'h10, ALU_ADD, 1, 0, 1);
        stepCycle();
        setIdle();
        loadInstr(5'd4, 5'd5, 5'd6, 32'hBAD, 32'h5, 32'h0, ALU_ADD, 0, 1, 0);
        bus.stall_i = 1;
        #1;
        checkOutput("lu_high", 32'(bus.load_use_o), 32'd1);
        stepCycle();
        #1;
        checkOutput("lu_stall_hold", 32'(bus.load_use_o), 32'd1);
        checkOutput("lu_stall_memrd", 32'(bus.ex_mem_read_o), 32'd1);
        bus.stall_i = 0;
        stepCycle();
        #1;
        checkOutput("lu_bubble_valid", 32'(bus.ex_valid_o), 32'd0);
        checkOutput("lu_bubble_clear", 32'(bus.load_use_o), 32'd0);
        stepCycle();
        setIdle();
        bus.wb_reg_write_i = 1; bus.wb_rd_i = 5'd4; bus.wb_result_i = 32'hCAFE;
        #1;
        checkOutput("lu_fwd_a", 32'(bus.fwd_a_o), 32'(2'b10));
        checkOutput("lu_x", bus.alu_x_o, 32'hCAFE);
        checkOutput("lu_valid", 32'(bus.ex_valid_o), 32'd1);

        // Stall for three cycles holds everything
        setIdle();
        loadInstr(5'd1, 5'd2, 5'd9, 32'h1111, 32'h2222, 32'h0, ALU_SUB, 0, 1, 0);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            bus.stall_i = 1; bus.flush_i = 0;
            bus.exm_reg_write_i = 0; bus.wb_reg_write_i = 0;
            #1;
            checkOutput("stall_x", bus.alu_x_o, 32'h1111);
            checkOutput("stall_dest", 32'(bus.dest_o), 32'd9);
            checkOutput("stall_ctrl", 32'(bus.alu_ctrl_o), 32'(ALU_SUB));
            stepCycle();
        end

        // Flush with stall gives a bubble
        setIdle();
        bus.stall_i = 1; bus.flush_i = 1;
        stepCycle();
        #1;
        checkOutput("flush_regwr", 32'(bus.ex_reg_write_o), 32'd0);
        checkOutput("flush_valid", 32'(bus.ex_valid_o), 32'd0);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                setIdle();
                #2;
                rst_n = 0;
                modelSlot = '{default: 0};
                #1;
                checkAll();
                @(negedge clk);
                rst_n = 1;
            end
            applyStimulus();
            stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
